// File: rtl/dmem_router_pkg.sv
// Shared types and sizing for the data-memory router and its response pipeline.
package dmem_router_pkg;

  localparam int unsigned TAG_W    = 4;
  localparam int unsigned MAX_NSLV = 8;
  localparam int unsigned MAX_RLAT = 4;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = 4;

  typedef struct packed {
    logic             valid;
    logic             mapped;
    logic [IDX_W-1:0] idx;
  } rsp_entry_t;

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Fixed-latency shift pipeline remembering which slave owes each accepted read.
module dmem_rsp_pipe
  import dmem_router_pkg::*;
#(
  parameter int unsigned RLAT = 1
) (
  input  logic       clk,
  input  logic       resetb,
  input  rsp_entry_t push,
  output rsp_entry_t head
);

  rsp_entry_t stage [RLAT];

  always_ff @(posedge clk) begin
    if (resetb) begin
      for (int unsigned i = 0; i < RLAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= push;
      for (int unsigned i = 1; i < RLAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign head = stage[RLAT-1];

endmodule

// File: rtl/dmem_router.sv
// Address-tag router from one master to NSLV slaves with fixed-latency read return
// and a sticky record of the first unmapped access.
module dmem_router
  import dmem_router_pkg::*;
#(
  parameter int unsigned            NSLV    = 2,
  parameter logic [NSLV*TAG_W-1:0]  SLV_TAG = {4'h2, 4'h0},
  parameter int unsigned            RLAT    = 1
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     m_wready,
  output logic                     m_wvalid,
  input  logic [ADDR_W-1:0]        m_waddr,
  input  logic [DATA_W-1:0]        m_wdata,
  input  logic [STRB_W-1:0]        m_wstrb,
  input  logic                     m_rready,
  output logic                     m_rvalid,
  input  logic [ADDR_W-1:0]        m_raddr,
  output logic                     m_rresp,
  output logic [DATA_W-1:0]        m_rdata,
  output logic [NSLV-1:0]          s_wready,
  input  logic [NSLV-1:0]          s_wvalid,
  output logic [ADDR_W-1:0]        s_waddr,
  output logic [DATA_W-1:0]        s_wdata,
  output logic [STRB_W-1:0]        s_wstrb,
  output logic [NSLV-1:0]          s_rready,
  input  logic [NSLV-1:0]          s_rvalid,
  output logic [ADDR_W-1:0]        s_raddr,
  input  logic [NSLV-1:0]          s_rresp,
  input  logic [NSLV*DATA_W-1:0]   s_rdata,
  output logic                     bus_err,
  output logic [ADDR_W-1:0]        err_addr
);

  logic             w_hit;
  logic             r_hit;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] r_idx;
  logic             w_unmapped;
  logic             r_unmapped;
  rsp_entry_t       push;
  rsp_entry_t       head;

  // Walk from the top index down so that duplicate tags resolve to the lowest slave.
  always_comb begin
    w_hit = 1'b0;
    r_hit = 1'b0;
    w_idx = '0;
    r_idx = '0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if (SLV_TAG[i*TAG_W +: TAG_W] == m_waddr[ADDR_W-1 -: TAG_W]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
      if (SLV_TAG[i*TAG_W +: TAG_W] == m_raddr[ADDR_W-1 -: TAG_W]) begin
        r_hit = 1'b1;
        r_idx = IDX_W'(i);
      end
    end
  end

  // Unmapped requests are accepted by the router itself.
  always_comb begin
    s_wready = '0;
    s_rready = '0;
    m_wvalid = m_wready;
    m_rvalid = m_rready;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (w_hit && (w_idx == IDX_W'(i))) begin
        s_wready[i] = m_wready;
        m_wvalid    = m_wready && s_wvalid[i];
      end
      if (r_hit && (r_idx == IDX_W'(i))) begin
        s_rready[i] = m_rready;
        m_rvalid    = m_rready && s_rvalid[i];
      end
    end
  end

  assign s_waddr = m_waddr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;
  assign s_raddr = m_raddr;

  assign w_unmapped  = m_wready && !w_hit;
  assign r_unmapped  = m_rready && !r_hit;
  assign push.valid  = m_rready && m_rvalid;
  assign push.mapped = r_hit;
  assign push.idx    = r_idx;

  dmem_rsp_pipe #(
    .RLAT (RLAT)
  ) u_rsp_pipe (
    .clk    (clk),
    .resetb (resetb),
    .push   (push),
    .head   (head)
  );

  // Return mux; responses are suppressed while reset is held.
  always_comb begin
    m_rdata = '0;
    m_rresp = 1'b1;
    if (!resetb && head.valid) begin
      m_rresp = 1'b0;
      if (head.mapped) begin
        for (int unsigned i = 0; i < NSLV; i++) begin
          if (head.idx == IDX_W'(i)) begin
            m_rdata = s_rdata[i*DATA_W +: DATA_W];
            m_rresp = s_rresp[i];
          end
        end
      end
    end
  end

  // First unmapped access wins; the write address takes priority within a cycle.
  always_ff @(posedge clk) begin
    if (resetb) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else if (!bus_err && (w_unmapped || r_unmapped)) begin
      bus_err  <= 1'b1;
      err_addr <= w_unmapped ? m_waddr : m_raddr;
    end
  end

endmodule

// File: doc/dmem_router.md
DMEM_ROUTER -- requirements
Module: dmem_router

Interface
REQ-001 Parameter NSLV, default 2: number of downstream slave ports, 1..8.
REQ-002 Parameter SLV_TAG, default {4'h2, 4'h0}: packed NSLV x 4-bit address tags; slave i owns addresses with addr[31:28] == SLV_TAG[i].
REQ-003 Parameter RLAT, default 1: fixed read-data latency in cycles after read acceptance, 1..4.
REQ-004 Ports:
  clk  in  1  clock.
  resetb  in  1  reset; synchronous, active-high (1 = reset).
  m_wready  in  1  master write request.
  m_wvalid  out  1  write accepted.
  m_waddr  in  32  write address.
  m_wdata  in  32  write data.
  m_wstrb  in  4  write byte strobes.
  m_rready  in  1  master read request.
  m_rvalid  out  1  read accepted.
  m_raddr  in  32  read address.
  m_rresp  out  1  read response ok (1) / error (0).
  m_rdata  out  32  read data.
  s_wready  out  NSLV  per-slave write request.
  s_wvalid  in  NSLV  per-slave write accept.
  s_waddr, s_wdata, s_wstrb  out  32/32/4  broadcast write payload.
  s_rready  out  NSLV  per-slave read request.
  s_rvalid  in  NSLV  per-slave read accept.
  s_raddr  out  32  broadcast read address.
  s_rresp  in  NSLV  per-slave response ok.
  s_rdata  in  NSLV*32  per-slave read data.
  bus_err  out  1  sticky unmapped-access flag.
  err_addr  out  32  address of first unmapped access.

Function
REQ-005 Decode shall be combinational: s_wready[i] = m_wready && waddr tag match i; s_rready[i] likewise on raddr; at most one bit set.
REQ-006 m_wvalid/m_rvalid shall be the selected slave's s_wvalid/s_rvalid, same cycle; a write or read is accepted when request and valid are both 1.
REQ-007 Tag collisions in SLV_TAG shall resolve to the lowest index.
REQ-008 Unmapped access (no tag match): router shall accept internally, m_wvalid/m_rvalid = 1 same cycle, write discarded, read returns m_rresp = 0, m_rdata = 32'h0.
REQ-009 On each accepted read, the router shall push {mapped, slave index} into an RLAT-deep shift pipeline; stage RLAT-1 selects m_rdata/m_rresp exactly RLAT cycles after acceptance.
REQ-010 When the pipeline output stage is empty (no read accepted RLAT cycles earlier), m_rdata = 32'h0 and m_rresp = 1.
REQ-011 Back-to-back reads to different slaves, one per cycle, shall each return data from the correct slave with no bubble.
REQ-012 Simultaneous read and write in one cycle shall be decoded independently, including to the same slave.
REQ-013 On the first unmapped acceptance, bus_err shall set and err_addr capture that address; later unmapped accesses shall not change err_addr; if read and write are both unmapped in that cycle, the write address wins.
REQ-014 bus_err/err_addr shall clear only on reset.

Reset
REQ-015 Reset shall clear the read pipeline (all stages empty), bus_err = 0, err_addr = 32'h0; outputs then follow REQ-010.
REQ-016 Reads accepted before or during a reset cycle shall produce no response afterwards; decode outputs remain combinational during reset.

Structure
REQ-017 Shared package holds tag width (4), max NSLV (8), max RLAT (4) and the pipeline-entry struct {valid, mapped, idx[2:0]}.
REQ-018 One sub-module, dmem_rsp_pipe, implements the RLAT-deep response shift pipeline.
REQ-019 All sequential logic shall use clk posedge with synchronous resetb.

Verification
REQ-020 NSLV=2, RLAT=1: read 0x2000_0004 with s_rvalid[1]=1, s_rdata[1]=0xDEAD_BEEF -> m_rvalid same cycle, m_rdata=0xDEAD_BEEF, m_rresp=1 next cycle.
REQ-021 RLAT=3: reads to slave0, slave1, slave0 on consecutive cycles -> data from 0,1,0 on cycles +3,+4,+5.
REQ-022 Write to 0x5000_0000 -> m_wvalid=1, no s_wready bit, bus_err=1, err_addr=0x5000_0000; later unmapped write 0x6000_0000 leaves err_addr unchanged.
REQ-023 Unmapped read 0x7000_0010 -> m_rresp=0, m_rdata=0 after RLAT cycles.
REQ-024 Read accepted, resetb=1 next cycle -> no response emitted, bus_err=0.
REQ-025 Same-cycle write to slave0 and read to slave1 -> s_wready=2'b01, s_rready=2'b10, both complete.
